// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and FSM state type for the register-file writer.
//   NUM_REGS : number of architectural registers
//   ADDR_W   : register index width
//   state_e  : writer FSM states (IDLE, CLEAR)
package regfile_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

endpackage

// File: rtl/decoder_5_32.sv
// decoder_5_32: 5-bit index plus enable to 32-bit one-hot.
// Ports:
//   i_idx    : register index
//   i_en     : enable; all outputs low when 0
//   o_onehot : one-hot select, bit i_idx set when enabled
module decoder_5_32
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0]   i_idx,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_writer.sv
// regfile_writer: 32-entry register file fed through a one-deep write staging
// register, with an optional zeroing sweep of all registers.
// Optional feature: define REGFILE_WRITER_CLEAR_EN to build the clear sweep;
// without it clr_req is ignored and the writer never leaves IDLE.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   wr_valid : write request present
//   wr_ready : write request can be accepted this cycle
//   wr_addr  : destination register index
//   wr_data  : write data
//   clr_req  : request a zeroing sweep of registers 1..31
//   busy     : write staged or sweep in progress
//   regs     : flat register contents, register k at [k*N +: N]
module regfile_writer
    import regfile_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [N-1:0]          wr_data,
    input  logic                  clr_req,
    output logic                  busy,
    output logic [NUM_REGS*N-1:0] regs
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    state_e              r_state;
    state_e              w_state_next;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_next;
    logic                r_stg_valid;
    logic [ADDR_W-1:0]   r_stg_addr;
    logic [N-1:0]        r_stg_data;
    logic                w_clr_start;
    logic                w_accept;
    logic                w_sweep;
    logic [NUM_REGS-1:0] w_wr_en;
    logic [NUM_REGS-1:0] w_clr_en;
    logic                w_unused_en0;

`ifdef REGFILE_WRITER_CLEAR_EN
    assign w_clr_start = (r_state == IDLE) && clr_req;
`else
    logic w_unused_clr_req;
    assign w_unused_clr_req = clr_req;
    assign w_clr_start      = 1'b0;
`endif

    // A pending clear blocks new writes so clear wins over a simultaneous write.
    assign wr_ready = (r_state == IDLE) && !w_clr_start;
    assign w_accept = wr_valid && wr_ready;
    assign w_sweep  = (r_state == CLEAR);
    assign busy     = w_sweep || r_stg_valid;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_clr_start) begin
                    w_state_next = CLEAR;
                    w_cnt_next   = FIRST_IDX;
                end
            end
            CLEAR: begin
                if (r_cnt == LAST_IDX) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_stg_valid <= 1'b0;
            r_stg_addr  <= '0;
            r_stg_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_stg_valid <= w_accept;
            if (w_accept) begin
                r_stg_addr <= wr_addr;
                r_stg_data <= wr_data;
            end
        end
    end

    decoder_5_32 u_wr_dec (
        .i_idx    (r_stg_addr),
        .i_en     (r_stg_valid),
        .o_onehot (w_wr_en)
    );

    decoder_5_32 u_clr_dec (
        .i_idx    (r_cnt),
        .i_en     (w_sweep),
        .o_onehot (w_clr_en)
    );

    // Register 0 has no storage, so its select lines go nowhere.
    assign w_unused_en0 = w_wr_en[0] ^ w_clr_en[0];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        if (k == 0) begin : g_zero
            assign regs[0 +: N] = '0;
        end else begin : g_store
            logic [N-1:0] r_reg;
            // Staging is never valid during a sweep, so the two enables never collide.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_reg <= '0;
                end else if (w_clr_en[k]) begin
                    r_reg <= '0;
                end else if (w_wr_en[k]) begin
                    r_reg <= r_stg_data;
                end
            end
            assign regs[k*N +: N] = r_reg;
        end
    end

endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: self-checking bench for regfile_writer.
// Directed table + sequences, then randomized traffic against a queue-based model.
module tb_regfile_writer;
    import regfile_pkg::*;

    localparam int unsigned N = 32;

`ifdef REGFILE_WRITER_CLEAR_EN
    localparam bit ClrEn = 1'b1;
`else
    localparam bit ClrEn = 1'b0;
`endif

    logic                  clk      = 1'b0;
    logic                  rst      = 1'b0;
    logic                  wr_valid = 1'b0;
    logic [ADDR_W-1:0]     wr_addr  = '0;
    logic [N-1:0]          wr_data  = '0;
    logic                  clr_req  = 1'b0;
    logic                  wr_ready;
    logic                  busy;
    logic [NUM_REGS*N-1:0] regs;

    regfile_writer #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .busy     (busy),
        .regs     (regs)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    function automatic logic [N-1:0] reg_at(input int k);
        return regs[k*N +: N];
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [N-1:0]      data;
    } wr_t;

    logic [N-1:0] m_regs [NUM_REGS];
    wr_t          m_q[$];
    int           m_sweep_left;

    function automatic void m_reset();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_q.delete();
        m_sweep_left = 0;
    endfunction

    function automatic logic m_ready();
        return !((m_sweep_left > 0) || (ClrEn && clr_req));
    endfunction

    function automatic logic m_busy();
        return (m_sweep_left > 0) || (m_q.size() > 0);
    endfunction

    // One rising edge with the inputs currently applied.
    function automatic void m_edge();
        logic acc;
        logic start;
        wr_t  w;
        acc   = wr_valid && m_ready();
        start = ClrEn && clr_req && (m_sweep_left == 0);
        if (m_q.size() > 0) begin
            w = m_q.pop_front();
            if (w.addr != 0) m_regs[w.addr] = w.data;
        end
        if (m_sweep_left > 0) begin
            m_regs[NUM_REGS - m_sweep_left] = '0;
            m_sweep_left--;
        end else if (start) begin
            m_sweep_left = NUM_REGS - 1;
        end
        if (acc) m_q.push_back('{addr: wr_addr, data: wr_data});
    endfunction

    task automatic chk_regs_model(input string name);
        int bad = -1;
        for (int k = NUM_REGS - 1; k >= 0; k--) begin
            if (reg_at(k) !== m_regs[k]) bad = k;
        end
        n_checks++;
        if (bad >= 0) begin
            n_errors++;
            $display("FAIL %s: reg %0d got %h expected %h", name, bad, reg_at(bad), m_regs[bad]);
        end
    endtask

    task automatic chk_regs_zero(input string name);
        foreach (m_regs[i]) m_regs[i] = '0;
        chk_regs_model(name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [N-1:0]      data;
        logic [ADDR_W-1:0] chk_idx;
        logic [N-1:0]      chk_val;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int bad;

        vecs[0] = '{5'd5,  32'hDEADBEEF, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{5'd0,  32'hFFFFFFFF, 5'd0,  32'h00000000};
        vecs[2] = '{5'd0,  32'h12345678, 5'd5,  32'hDEADBEEF};
        vecs[3] = '{5'd31, 32'hA5A5A5A5, 5'd31, 32'hA5A5A5A5};
        vecs[4] = '{5'd1,  32'h12345678, 5'd1,  32'h12345678};
        vecs[5] = '{5'd31, 32'h00000001, 5'd31, 32'h00000001};
        vecs[6] = '{5'd1,  32'hFFFFFFFF, 5'd31, 32'h00000001};

        // Reset state while reset is held.
        m_reset();
        #12;
        chk_regs_zero("reset_regs");
        chk1("reset_ready", wr_ready, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1;
            wr_addr  = vecs[i].addr;
            wr_data  = vecs[i].data;
            @(negedge clk);
            chk1($sformatf("tbl%0d_ready", i), wr_ready, 1'b1);
            tick();
            wr_valid = 1'b0;
            @(negedge clk);
            chk1($sformatf("tbl%0d_busy_staged", i), busy, 1'b1);
            tick();
            @(negedge clk);
            if (vecs[i].addr != 0) m_regs[vecs[i].addr] = vecs[i].data;
            chk($sformatf("tbl%0d_reg%0d", i, vecs[i].chk_idx), reg_at(int'(vecs[i].chk_idx)),
                vecs[i].chk_val);
            chk1($sformatf("tbl%0d_busy_done", i), busy, 1'b0);
            chk_regs_model($sformatf("tbl%0d_all_regs", i));
            tick();
        end

        // Back-to-back writes to one address: no bubble, last value wins.
        for (int v = 1; v <= 3; v++) begin
            wr_valid = 1'b1;
            wr_addr  = 5'd3;
            wr_data  = N'(v);
            @(negedge clk);
            chk1($sformatf("b2b_ready%0d", v), wr_ready, 1'b1);
            tick();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("b2b_reg3_mid", reg_at(3), 32'h2);
        chk1("b2b_busy_mid", busy, 1'b1);
        tick();
        @(negedge clk);
        chk("b2b_reg3_end", reg_at(3), 32'h3);
        chk1("b2b_busy_end", busy, 1'b0);
        tick();

`ifdef REGFILE_WRITER_CLEAR_EN
        // Fill 1..31 with their index, then sweep.
        bad = 0;
        for (int k = 1; k < 32; k++) begin
            wr_valid = 1'b1;
            wr_addr  = ADDR_W'(k);
            wr_data  = N'(k);
            @(negedge clk);
            if (wr_ready !== 1'b1) bad++;
            tick();
            m_regs[k] = N'(k);
        end
        wr_valid = 1'b0;
        chk("fill_ready_stalls", N'(bad), 32'h0);
        tick();
        @(negedge clk);
        chk_regs_model("fill_regs");
        tick();
        clr_req = 1'b1;
        @(negedge clk);
        chk1("clr_req_ready", wr_ready, 1'b0);
        tick();
        clr_req = 1'b0;
        bad = 0;
        for (int c = 0; c < 31; c++) begin
            @(negedge clk);
            if (wr_ready !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        chk("clr_bad_cycles", N'(bad), 32'h0);
        @(negedge clk);
        chk_regs_zero("clr_regs_zero");
        chk1("clr_end_ready", wr_ready, 1'b1);
        chk1("clr_end_busy", busy, 1'b0);
        tick();

        // Staged write committed on the start edge; simultaneous write rejected.
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        tick();
        wr_addr = 5'd9; wr_data = 32'h99;
        tick();
        clr_req = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        @(negedge clk);
        chk1("race_ready", wr_ready, 1'b0);
        chk1("race_busy_staged", busy, 1'b1);
        tick();
        clr_req = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        chk("race_reg9_committed", reg_at(9), 32'h99);
        chk("race_reg7_kept", reg_at(7), 32'h77);
        tick();
        @(negedge clk);
        chk("race_reg7_not_written", reg_at(7), 32'h77);
        for (int c = 0; c < 30; c++) tick();
        @(negedge clk);
        chk_regs_zero("race_regs_zero");
        chk1("race_end_busy", busy, 1'b0);
        tick();

        // Reset at sweep cycle 10 with regs 20..31 loaded.
        for (int k = 20; k < 32; k++) begin
            wr_valid = 1'b1;
            wr_addr  = ADDR_W'(k);
            wr_data  = 32'hA000_0000 | N'(k);
            tick();
        end
        wr_valid = 1'b0;
        tick();
        chk("rstsweep_reg25_loaded", reg_at(25), 32'hA000_0019);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        #2;
        rst = 1'b0;
        #1;
        chk_regs_zero("rstsweep_regs");
        chk1("rstsweep_ready", wr_ready, 1'b1);
        chk1("rstsweep_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        @(negedge clk);
        chk1("rstsweep_after_busy", busy, 1'b0);
        chk1("rstsweep_after_ready", wr_ready, 1'b1);
        chk_regs_zero("rstsweep_after_regs");
        tick();
`endif

        // Reset with a write staged: no commit after release.
        wr_valid = 1'b1; wr_addr = 5'd12; wr_data = 32'h1212;
        tick();
        wr_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk1("rststg_busy", busy, 1'b0);
        chk("rststg_reg12", reg_at(12), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rststg_reg12_after", reg_at(12), 32'h0);
        chk1("rststg_busy_after", busy, 1'b0);
        tick();

        // Randomized traffic against the model.
        m_reset();
        for (int c = 0; c < 800; c++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_addr  = ($urandom_range(0, 3) == 0) ? 5'd3 : ADDR_W'($urandom_range(0, 31));
            wr_data  = $urandom;
            clr_req  = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            chk1("rnd_ready", wr_ready, m_ready());
            chk1("rnd_busy", busy, m_busy());
            chk_regs_model("rnd_regs");
            @(posedge clk);
            m_edge();
            #1;
        end
        wr_valid = 1'b0;
        clr_req  = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
